edge_generator: RTL and testbench
=================================

# edge_generator

Transmit-side companion to the Si570 controller's input edge detector/debouncer. It converts single-cycle trigger requests into a clean, fixed-width active-low pulse on an output line. Each pulse is followed by a mandatory guard interval, so a debounced receiver on the far end sees exactly one falling and one rising edge per request. One request may be queued during a busy period; requests beyond that are dropped and counted.

## Interface
Parameters:
- PULSE_WIDTH, default 16'h0100: cycles the line is held at the active level; legal range 1..65535.
- GUARD_CYCLES, default 16'hf00f: cycles the line is held idle after each pulse, before another pulse may start; legal range 1..65535.
- IDLE_LEVEL, default 1'b1: idle level of oOUT. The active level is ~IDLE_LEVEL.

Ports:
- iCLK, input, 1: the only clock. All logic is rising-edge triggered.
- iRST_n, input, 1: asynchronous, active-low reset.
- iTRIGGER, input, 1: pulse request, sampled on every rising edge. Holding it high for N cycles counts as N requests.
- oOUT, output, 1: the generated line. Registered.
- oBUSY, output, 1: high whenever the state is ACTIVE or GUARD. Registered.
- oDONE, output, 1: one-cycle strobe on the cycle after GUARD terminates.
- oPENDING, output, 1: a queued request is held.
- oDROP_CNT, output, 8: count of dropped requests; saturates at 8'hff.

## Operation
- The state machine has three states: IDLE, ACTIVE, GUARD. It uses a 16-bit down-counter cnt.
- IDLE:
  - oOUT = IDLE_LEVEL.
  - On iTRIGGER: state goes to ACTIVE, cnt loads PULSE_WIDTH-1, oOUT goes to ~IDLE_LEVEL.
- ACTIVE:
  - cnt decrements each cycle.
  - When cnt==0: state goes to GUARD, cnt loads GUARD_CYCLES-1, oOUT returns to IDLE_LEVEL.
- GUARD:
  - cnt decrements each cycle.
  - When cnt==0 (the terminal cycle), oDONE is asserted on the next cycle, and:
    - If pending or iTRIGGER is set: state goes to ACTIVE, cnt loads PULSE_WIDTH-1, oOUT goes to ~IDLE_LEVEL.
    - Otherwise: state goes to IDLE.
- Pending slot, for iTRIGGER seen while in ACTIVE, or in GUARD on a non-terminal cycle:
  - If pending is clear, it is set.
  - If pending is already set, oDROP_CNT increments, saturating at 255.
- Pending slot on the GUARD terminal cycle:
  - pending=1 and iTRIGGER=1: pending is consumed and the trigger refills it, so pending stays 1. No drop.
  - Exactly one of the two set: it is consumed and pending becomes 0.
- IDLE never holds a pending request; pending=0 there by construction.
- oDROP_CNT is cleared only by reset.
- Reset takes effect at any time, including mid-pulse or mid-guard:
  - state=IDLE, cnt=0, pending=0.
  - oOUT=IDLE_LEVEL, oBUSY=0, oDONE=0, oPENDING=0, oDROP_CNT=0.
  - A pulse truncated by reset is not resumed.

## Timing
- Latency: a trigger sampled at edge T puts oOUT at the active level from edge T. It stays there for exactly PULSE_WIDTH cycles and returns to idle at edge T+PULSE_WIDTH.
- oBUSY rises together with oOUT's first active edge. It falls on the edge that enters IDLE, which is T+PULSE_WIDTH+GUARD_CYCLES for an isolated trigger.
- The minimum repeat period is PULSE_WIDTH+GUARD_CYCLES cycles. Back-to-back queued pulses achieve exactly this period.
- oDONE is high for the single cycle following GUARD exit. This coincides with the first IDLE cycle, or the first ACTIVE cycle of a chained pulse.
- All outputs are registered; no combinational path runs from iTRIGGER to any output.

## Test plan
For all scenarios: PULSE_WIDTH=4, GUARD_CYCLES=8, IDLE_LEVEL=1.
- Reset and isolated trigger: release reset and pulse iTRIGGER at edge 10.
  - oOUT=0 during edges 10..13 and 1 from edge 14.
  - oBUSY=1 during edges 10..21.
  - oDONE=1 for the single cycle after edge 22.
  - oDROP_CNT=0.
- Queued request: triggers at edges 10 and 16.
  - oOUT low during edges 10..13 and again during 22..25.
  - oPENDING high during edges 17..22.
  - oBUSY stays continuously high.
  - oDONE pulses at edges 22 and 34.
- Drops and saturation: trigger held high for 300 cycles starting while idle.
  - Pulses repeat every 12 cycles.
  - oDROP_CNT climbs and saturates at 8'hff without wrapping.
- Terminal-cycle collision: pending set and iTRIGGER high on the GUARD terminal cycle.
  - Next pulse starts immediately and oPENDING stays 1.
  - A third pulse follows 12 cycles later.
  - oDROP_CNT unchanged.
- Reset mid-pulse: assert iRST_n=0 two cycles into ACTIVE.
  - oOUT returns to 1 asynchronously, with no clock edge required.
  - oBUSY=0, oPENDING=0, oDROP_CNT=0.
  - No pulse occurs after reset is released.
- IDLE_LEVEL=0 variant: isolated trigger gives oOUT high for exactly 4 cycles, otherwise 0.

Source files
------------

// File: rtl/edge_generator.sv
// Converts single-cycle trigger requests into fixed-width pulses, each followed by a guard interval.
// Holds one queued request while busy and counts any further requests as drops.
module edge_generator #(
  parameter logic [15:0] PULSE_WIDTH  = 16'h0100,
  parameter logic [15:0] GUARD_CYCLES = 16'hf00f,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iTRIGGER,
  output logic       oOUT,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oPENDING,
  output logic [7:0] oDROP_CNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        pending;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hff) ? value : value + 8'd1;
  endfunction

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      pending   <= 1'b0;
      oOUT      <= IDLE_LEVEL;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oPENDING  <= 1'b0;
      oDROP_CNT <= 8'd0;
    end else begin
      oDONE    <= 1'b0;
      // oPENDING is a registered copy of the slot, so it trails the slot by one cycle
      oPENDING <= pending;
      case (state)
        IDLE: begin
          if (iTRIGGER) begin
            state <= ACTIVE;
            cnt   <= PULSE_WIDTH - 16'd1;
            oOUT  <= ~IDLE_LEVEL;
            oBUSY <= 1'b1;
          end
        end
        ACTIVE: begin
          if (iTRIGGER) begin
            if (pending) oDROP_CNT <= sat_inc(oDROP_CNT);
            else         pending   <= 1'b1;
          end
          if (cnt == 16'd0) begin
            state <= GUARD;
            cnt   <= GUARD_CYCLES - 16'd1;
            oOUT  <= IDLE_LEVEL;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GUARD: begin
          if (cnt == 16'd0) begin
            // terminal cycle: a queued request and a fresh trigger together refill the slot
            oDONE   <= 1'b1;
            pending <= pending & iTRIGGER;
            if (pending || iTRIGGER) begin
              state <= ACTIVE;
              cnt   <= PULSE_WIDTH - 16'd1;
              oOUT  <= ~IDLE_LEVEL;
            end else begin
              state <= IDLE;
              oBUSY <= 1'b0;
            end
          end else begin
            cnt <= cnt - 16'd1;
            if (iTRIGGER) begin
              if (pending) oDROP_CNT <= sat_inc(oDROP_CNT);
              else         pending   <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 16'd0;
          pending <= 1'b0;
          oOUT    <= IDLE_LEVEL;
          oBUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_generator.sv
// Directed bench for edge_generator with PULSE_WIDTH=4, GUARD_CYCLES=8.
// Relative edge k=0 is the edge that samples the first trigger of each scenario.
module tb_edge_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig;
  logic       trig0;
  logic       out, busy, done, pend;
  logic [7:0] drop;
  logic       out0, busy0, done0, pend0;
  logic [7:0] drop0;
  int         checks = 0;
  int         errors = 0;
  int         exp_drop;

  always #5 clk = ~clk;

  edge_generator #(
    .PULSE_WIDTH(16'd4), .GUARD_CYCLES(16'd8), .IDLE_LEVEL(1'b1)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iTRIGGER(trig),
    .oOUT(out), .oBUSY(busy), .oDONE(done), .oPENDING(pend), .oDROP_CNT(drop)
  );

  edge_generator #(
    .PULSE_WIDTH(16'd4), .GUARD_CYCLES(16'd8), .IDLE_LEVEL(1'b0)
  ) dut0 (
    .iCLK(clk), .iRST_n(rst_n), .iTRIGGER(trig0),
    .oOUT(out0), .oBUSY(busy0), .oDONE(done0), .oPENDING(pend0), .oDROP_CNT(drop0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    trig  = 1'b0;
    trig0 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_out",  32'(out),  32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pend", 32'(pend), 32'd0);
    check_eq("rst_drop", 32'(drop), 32'd0);
    check_eq("rst_out0", 32'(out0), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // isolated trigger
    for (int k = 0; k <= 20; k++) begin
      trig = (k == 0);
      tick();
      trig = 1'b0;
      check_eq($sformatf("iso_out_k%0d", k),  32'(out),  32'(k >= 4));
      check_eq($sformatf("iso_busy_k%0d", k), 32'(busy), 32'(k < 12));
      check_eq($sformatf("iso_done_k%0d", k), 32'(done), 32'(k == 12));
      check_eq($sformatf("iso_drop_k%0d", k), 32'(drop), 32'd0);
    end

    // queued request at k=6
    for (int k = 0; k <= 30; k++) begin
      trig = (k == 0 || k == 6);
      tick();
      trig = 1'b0;
      check_eq($sformatf("q_out_k%0d", k),  32'(out),  32'(!(k < 4 || (k >= 12 && k < 16))));
      check_eq($sformatf("q_pend_k%0d", k), 32'(pend), 32'(k >= 7 && k <= 12));
      check_eq($sformatf("q_busy_k%0d", k), 32'(busy), 32'(k < 24));
      check_eq($sformatf("q_done_k%0d", k), 32'(done), 32'(k == 12 || k == 24));
    end

    // pending set and fresh trigger on the guard terminal cycle (k=12)
    for (int k = 0; k <= 40; k++) begin
      trig = (k == 0 || k == 6 || k == 12);
      tick();
      trig = 1'b0;
      check_eq($sformatf("col_out_k%0d", k),  32'(out),  32'(!(k < 36 && (k % 12) < 4)));
      check_eq($sformatf("col_pend_k%0d", k), 32'(pend), 32'(k >= 7 && k <= 24));
      check_eq($sformatf("col_busy_k%0d", k), 32'(busy), 32'(k < 36));
      check_eq($sformatf("col_done_k%0d", k), 32'(done), 32'(k == 12 || k == 24 || k == 36));
      check_eq($sformatf("col_drop_k%0d", k), 32'(drop), 32'd0);
    end

    // trigger held for 300 cycles: first busy trigger fills the slot, later non-terminal ones drop
    exp_drop = 0;
    for (int k = 0; k < 300; k++) begin
      trig = 1'b1;
      tick();
      if (k >= 2 && (k % 12) != 0 && exp_drop < 255) exp_drop++;
      check_eq($sformatf("hold_out_k%0d", k),  32'(out),  32'((k % 12) >= 4));
      check_eq($sformatf("hold_drop_k%0d", k), 32'(drop), 32'(exp_drop));
    end
    trig = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check_eq("hold_idle_busy", 32'(busy), 32'd0);
    check_eq("hold_sat_drop",  32'(drop), 32'hff);

    // reset two cycles into ACTIVE with a request queued
    for (int k = 0; k <= 2; k++) begin
      trig = (k == 0 || k == 1);
      tick();
      trig = 1'b0;
    end
    check_eq("mid_out_pre",  32'(out),  32'd0);
    check_eq("mid_pend_pre", 32'(pend), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_out_async",  32'(out),  32'd1);
    check_eq("mid_busy_async", 32'(busy), 32'd0);
    check_eq("mid_pend_async", 32'(pend), 32'd0);
    check_eq("mid_drop_async", 32'(drop), 32'd0);
    check_eq("mid_done_async", 32'(done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq($sformatf("post_out_k%0d", k),  32'(out),  32'd1);
      check_eq($sformatf("post_busy_k%0d", k), 32'(busy), 32'd0);
    end

    // active-high variant
    check_eq("inv_out_idle", 32'(out0), 32'd0);
    for (int k = 0; k <= 20; k++) begin
      trig0 = (k == 0);
      tick();
      trig0 = 1'b0;
      check_eq($sformatf("inv_out_k%0d", k),  32'(out0),  32'(k < 4));
      check_eq($sformatf("inv_busy_k%0d", k), 32'(busy0), 32'(k < 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
